// File: rtl/mod_addsub.sv
// mod_addsub: (a +/- b) mod M on 1024-bit operands, sequencing one or two passes through mpadder.
// Latency 2L+4 (L+3 when a subtraction is already non-negative); start is ignored unless idle.

module mpadder (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic          subtract,
   input  logic [1026:0] in_a,
   input  logic [1026:0] in_b,
   output logic [1027:0] result,
   output logic          done
);
   localparam int CW = 257;

   logic [1027:0] r_a;
   logic [1027:0] r_b;
   logic [1027:0] r_sum;
   logic          r_carry;
   logic          r_done;
   logic [2:0]    r_cnt;
   logic [CW:0]   w_chunk;

   // Four 257-bit ripple steps; subtraction is a + ~b + 1 taken modulo 2^1028.
   assign w_chunk = {1'b0, r_a[CW-1:0]} + {1'b0, r_b[CW-1:0]} + {{CW{1'b0}}, r_carry};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= 3'd0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_a     <= {1'b0, in_a};
            r_b     <= subtract ? ~{1'b0, in_b} : {1'b0, in_b};
            r_carry <= subtract;
            r_cnt   <= 3'd4;
         end else if (r_cnt != 3'd0) begin
            r_sum   <= {w_chunk[CW-1:0], r_sum[1027:CW]};
            r_a     <= r_a >> CW;
            r_b     <= r_b >> CW;
            r_carry <= w_chunk[CW];
            r_cnt   <= r_cnt - 3'd1;
            r_done  <= (r_cnt == 3'd1);
         end
      end
   end

   assign result = r_sum;
   assign done   = r_done;
endmodule

module mod_addsub (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic          subtract,
   input  logic [1023:0] in_a,
   input  logic [1023:0] in_b,
   input  logic [1023:0] in_m,
   output logic [1023:0] result,
   output logic          done,
   output logic          busy
);
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2, S_FINISH
   } state_t;

   state_t        r_state;
   logic [1023:0] r_a;
   logic [1023:0] r_b;
   logic [1023:0] r_m;
   logic          r_sub;
   logic [1026:0] r_s;
   logic          r_mp_start;
   logic [1023:0] r_result;
   logic          r_done;
   logic          r_busy;

   logic          w_pass2;
   logic [1026:0] w_mp_a;
   logic [1026:0] w_mp_b;
   logic          w_mp_sub;
   logic [1027:0] w_mp_res;
   logic          w_mp_done;

   // Pass 2 always combines the pass-1 value with M using the opposite operation.
   assign w_pass2  = (r_state == S_ISSUE2) || (r_state == S_WAIT2);
   assign w_mp_a   = w_pass2 ? r_s : {3'b000, r_a};
   assign w_mp_b   = w_pass2 ? {3'b000, r_m} : {3'b000, r_b};
   assign w_mp_sub = w_pass2 ? ~r_sub : r_sub;

   mpadder u_mpadder (
      .clk      (clk),
      .resetn   (resetn),
      .start    (r_mp_start),
      .subtract (w_mp_sub),
      .in_a     (w_mp_a),
      .in_b     (w_mp_b),
      .result   (w_mp_res),
      .done     (w_mp_done)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_m        <= '0;
         r_sub      <= 1'b0;
         r_s        <= '0;
         r_mp_start <= 1'b0;
         r_result   <= '0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_mp_start <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_busy <= start;
               if (start) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_m     <= in_m;
                  r_sub   <= subtract;
                  r_state <= S_ISSUE1;
               end
            end
            S_ISSUE1: begin
               r_mp_start <= 1'b1;
               r_state    <= S_WAIT1;
            end
            S_WAIT1: begin
               if (w_mp_done) begin
                  r_s <= w_mp_res[1026:0];
                  if (r_sub && !w_mp_res[1027]) begin
                     r_state <= S_FINISH;
                  end else begin
                     // Pass-2 pulse launches here so its operands (r_s) are stable from the pulse cycle.
                     r_mp_start <= 1'b1;
                     r_state    <= S_ISSUE2;
                  end
               end
            end
            S_ISSUE2: begin
               r_state <= S_WAIT2;
            end
            S_WAIT2: begin
               if (w_mp_done) begin
                  if (r_sub || !w_mp_res[1027]) begin
                     r_s <= w_mp_res[1026:0];
                  end
                  r_state <= S_FINISH;
               end
            end
            S_FINISH: begin
               r_result <= r_s[1023:0];
               r_done   <= 1'b1;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign result = r_result;
   assign done   = r_done;
   assign busy   = r_busy;
endmodule

// File: tb/tb_mod_addsub.sv
// Directed and random checks of mod_addsub against an arithmetic reference model.

module tb_mod_addsub;
   localparam int L = 5;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic          subtract = 1'b0;
   logic [1023:0] in_a = '0;
   logic [1023:0] in_b = '0;
   logic [1023:0] in_m = '0;
   logic [1023:0] result;
   logic          done;
   logic          busy;

   int            n_assert = 0;
   int            n_fail = 0;

   logic          nx_sub;
   logic [1023:0] nx_a;
   logic [1023:0] nx_b;
   logic [1023:0] nx_m;

   mod_addsub dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .subtract (subtract),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_m     (in_m),
      .result   (result),
      .done     (done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] want);
      logic [127:0] o_lo;
      logic [127:0] w_lo;
      o_lo = obs[127:0];
      w_lo = want[127:0];
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (low 128 bits)", tag, o_lo, w_lo);
      end
   endtask

   function automatic logic [1023:0] rnd1024();
      logic [1023:0] v;
      for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [1023:0] model(input logic sub, input logic [1023:0] a,
                                           input logic [1023:0] b, input logic [1023:0] m);
      logic [1024:0] s;
      if (!sub) begin
         s = {1'b0, a} + {1'b0, b};
         if (s >= {1'b0, m}) s = s - {1'b0, m};
      end else if (a >= b) begin
         s = {1'b0, a} - {1'b0, b};
      end else begin
         s = {1'b0, a} + {1'b0, m} - {1'b0, b};
      end
      return s[1023:0];
   endfunction

   task automatic run_op(input string tag, input logic sub, input logic [1023:0] a,
                         input logic [1023:0] b, input logic [1023:0] m,
                         input bit launch, input bit poke, input bit scramble, input bit chain);
      logic [1023:0] want;
      int            want_lat;
      int            k;
      bit            got;
      int            extra;
      want     = model(sub, a, b, m);
      want_lat = (sub && a >= b) ? L + 3 : 2 * L + 4;
      if (launch) begin
         @(negedge clk);
         subtract = sub; in_a = a; in_b = b; in_m = m; start = 1'b1;
      end
      k = 0;
      got = 0;
      while (!got && k < 400) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            start = 1'b0;
            chk({tag, "/busy_on"}, 1024'(busy), 1024'(1));
         end
         if (poke && k == 3) start = 1'b1;
         if (poke && k == 4) start = 1'b0;
         if (poke && k == want_lat) start = 1'b1;
         if (poke && k == want_lat + 1) start = 1'b0;
         if (scramble && k == 2) begin
            in_a = rnd1024(); in_b = rnd1024(); in_m = rnd1024(); subtract = ~subtract;
         end
         if (done) got = 1;
      end
      chk({tag, "/done_seen"}, 1024'(got), 1024'(1));
      chk({tag, "/latency"}, 1024'(k - 1), 1024'(want_lat));
      chk({tag, "/result"}, result, want);
      if (chain) begin
         subtract = nx_sub; in_a = nx_a; in_b = nx_b; in_m = nx_m; start = 1'b1;
      end else begin
         @(negedge clk);
         chk({tag, "/done_pulse"}, 1024'(done), 1024'(0));
         chk({tag, "/busy_off"}, 1024'(busy), 1024'(0));
         chk({tag, "/held"}, result, want);
         if (poke) begin
            extra = 0;
            repeat (30) begin
               @(negedge clk);
               if (done) extra++;
            end
            chk({tag, "/extra_done"}, 1024'(extra), 1024'(0));
         end
      end
   endtask

   initial begin
      logic [1023:0] mfull;
      logic [1023:0] ra;
      logic [1023:0] rb;
      logic [1023:0] rm;
      int            extra;

      #2;
      chk("reset/result", result, '0);
      chk("reset/done", 1024'(done), 1024'(0));
      chk("reset/busy", 1024'(busy), 1024'(0));
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      run_op("add_7_9", 1'b0, 1024'd7, 1024'd9, 1024'd13, 1, 0, 0, 0);
      run_op("add_12_1", 1'b0, 1024'd12, 1024'd1, 1024'd13, 1, 0, 0, 0);
      run_op("add_0_0", 1'b0, 1024'd0, 1024'd0, 1024'd13, 1, 0, 0, 0);
      run_op("add_5_6", 1'b0, 1024'd5, 1024'd6, 1024'd13, 1, 0, 0, 0);
      run_op("sub_3_9", 1'b1, 1024'd3, 1024'd9, 1024'd13, 1, 0, 0, 0);
      run_op("sub_9_3", 1'b1, 1024'd9, 1024'd3, 1024'd13, 1, 0, 0, 0);
      run_op("sub_5_5", 1'b1, 1024'd5, 1024'd5, 1024'd13, 1, 0, 0, 0);

      mfull = '1;
      run_op("full_add", 1'b0, mfull - 1024'd1, mfull - 1024'd1, mfull, 1, 0, 0, 0);
      run_op("full_sub", 1'b1, mfull - 1024'd1, mfull - 1024'd1, mfull, 1, 0, 0, 0);

      run_op("poke_add", 1'b0, 1024'd7, 1024'd9, 1024'd13, 1, 1, 0, 0);
      run_op("poke_sub1", 1'b1, 1024'd9, 1024'd3, 1024'd13, 1, 1, 0, 0);
      run_op("scramble", 1'b1, 1024'd3, 1024'd9, 1024'd13, 1, 0, 1, 0);

      nx_sub = 1'b1; nx_a = 1024'd9; nx_b = 1024'd3; nx_m = 1024'd13;
      run_op("b2b_first", 1'b0, 1024'd7, 1024'd9, 1024'd13, 1, 0, 0, 1);
      run_op("b2b_second", 1'b1, 1024'd9, 1024'd3, 1024'd13, 0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         rm = rnd1024() >> $urandom_range(0, 1000);
         if (rm == '0) rm = 1024'd1;
         ra = rnd1024() % rm;
         rb = rnd1024() % rm;
         run_op($sformatf("rand_%s%0d", (i % 2) ? "sub" : "add", i), 1'(i % 2), ra, rb, rm, 1, 0, 0, 0);
      end

      run_op("pre_reset", 1'b0, 1024'd5, 1024'd6, 1024'd13, 1, 0, 0, 0);
      @(negedge clk);
      subtract = 1'b0; in_a = 1024'd7; in_b = 1024'd9; in_m = 1024'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("rst/busy_pre", 1024'(busy), 1024'(1));
      resetn = 1'b0;
      #1;
      chk("rst/result", result, '0);
      chk("rst/done", 1024'(done), 1024'(0));
      chk("rst/busy", 1024'(busy), 1024'(0));
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      extra = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("rst/no_done", 1024'(extra), 1024'(0));
      run_op("rst_after", 1'b0, 1024'd7, 1024'd9, 1024'd13, 1, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
